// File: rtl/tap_controller_if.sv
// JTAG TAP pin and DR-control bundle.
// master: pin driver and test data registers; slave: tap_controller.
interface tap_controller_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;
    logic clockDR;
    logic captureDR;
    logic shiftDR;
    logic updateDR;
    logic select_idcode;
    logic select_bypass;
    logic idcode_tdo;
    logic usercode_sel;

    modport master (
        output tms,
        output tdi,
        output idcode_tdo,
        input  tdo,
        input  tdo_en,
        input  clockDR,
        input  captureDR,
        input  shiftDR,
        input  updateDR,
        input  select_idcode,
        input  select_bypass,
        input  usercode_sel
    );

    modport slave (
        input  tms,
        input  tdi,
        input  idcode_tdo,
        output tdo,
        output tdo_en,
        output clockDR,
        output captureDR,
        output shiftDR,
        output updateDR,
        output select_idcode,
        output select_bypass,
        output usercode_sel
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TMS FSM, instruction register with
// decode, bypass register, DR control strobes and the tdo output mux.
// Optional feature macro: TAP_USERCODE_EN (USERCODE opcode selects the ID
// register path and raises usercode_sel; otherwise it decodes as bypass).
module tap_controller #(
    parameter int unsigned         IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP   = IR_WIDTH'(4'b0001),
    parameter logic [IR_WIDTH-1:0] BYPASS_OP   = '1,
    parameter logic [IR_WIDTH-1:0] USERCODE_OP = IR_WIDTH'(4'b0010)
) (
    input  logic            tck,
    input  logic            trst,
    tap_controller_if.slave bus
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EXIT1_DR = 4'd5,
        PAUSE_DR = 4'd6,
        EXIT2_DR = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EXIT1_IR = 4'd12,
        PAUSE_IR = 4'd13,
        EXIT2_IR = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    // Value loaded into the IR shift stage in Capture-IR: LSB=1, bit1=0.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_next;
    logic                bypass_q;
    logic                sel_idcode_q;
    logic                sel_bypass_q;
    logic                usercode_q;
    logic [2:0]          dec_next;
    logic                tdo_q;
    logic                tdo_en_q;
    logic                dr_clk_en;

    // Standard 1149.1 state transition table.
    function automatic tap_state_t next_state(input tap_state_t cur, input logic t);
        tap_state_t nxt;
        nxt = cur;
        case (cur)
            TLR:      nxt = t ? TLR      : RTI;
            RTI:      nxt = t ? SEL_DR   : RTI;
            SEL_DR:   nxt = t ? SEL_IR   : CAP_DR;
            CAP_DR:   nxt = t ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: nxt = t ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: nxt = t ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: nxt = t ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: nxt = t ? UPD_DR   : SHIFT_DR;
            UPD_DR:   nxt = t ? SEL_DR   : RTI;
            SEL_IR:   nxt = t ? TLR      : CAP_IR;
            CAP_IR:   nxt = t ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: nxt = t ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: nxt = t ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: nxt = t ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: nxt = t ? UPD_IR   : SHIFT_IR;
            UPD_IR:   nxt = t ? SEL_DR   : RTI;
            default:  nxt = TLR;
        endcase
        return nxt;
    endfunction

    // Instruction decode: {usercode_sel, select_idcode, select_bypass}.
    // Every opcode that does not select the ID path selects bypass, so the
    // two select outputs are always mutually exclusive.
    function automatic logic [2:0] decode(input logic [IR_WIDTH-1:0] op);
        logic user_hit;
        logic id_hit;
`ifdef TAP_USERCODE_EN
        user_hit = (op == USERCODE_OP);
        id_hit   = (op == IDCODE_OP) || user_hit;
`else
        // USERCODE is an undefined opcode in this build.
        user_hit = 1'b0;
        id_hit   = (op == IDCODE_OP) && (op != USERCODE_OP);
`endif
        return {user_hit, id_hit, (op == BYPASS_OP) || !id_hit};
    endfunction

    // TAP state register, advanced by tms on rising tck.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state <= TLR;
        end else begin
            state <= next_state(state, bus.tms);
        end
    end

    // IR shift stage: capture fixed pattern, shift right with tdi into MSB.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_shift <= IR_CAPTURE;
        end else if (state == CAP_IR) begin
            ir_shift <= IR_CAPTURE;
        end else if (state == SHIFT_IR) begin
            ir_shift <= {bus.tdi, ir_shift[IR_WIDTH-1:1]};
        end
    end

    // Single-bit bypass register.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            bypass_q <= 1'b0;
        end else if (state == CAP_DR) begin
            bypass_q <= 1'b0;
        end else if (state == SHIFT_DR) begin
            bypass_q <= bus.tdi;
        end
    end

    // Next latched IR: reload IDCODE in Test-Logic-Reset, take shift stage in Update-IR.
    always_comb begin
        ir_next = ir;
        if (state == TLR) begin
            ir_next = IDCODE_OP;
        end else if (state == UPD_IR) begin
            ir_next = ir_shift;
        end
    end

    // Decode of the IR value about to be latched.
    always_comb begin
        dec_next = decode(ir_next);
    end

    // Latched IR and registered decode, updated on falling tck.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            ir           <= IDCODE_OP;
            usercode_q   <= 1'b0;
            sel_idcode_q <= 1'b1;
            sel_bypass_q <= 1'b0;
        end else begin
            ir                                       <= ir_next;
            {usercode_q, sel_idcode_q, sel_bypass_q} <= dec_next;
        end
    end

    // Falling-edge tdo mux, tdo enable and DR clock gate enable.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo_q     <= 1'b0;
            tdo_en_q  <= 1'b0;
            dr_clk_en <= 1'b0;
        end else begin
            dr_clk_en <= (state == CAP_DR) || (state == SHIFT_DR);
            tdo_en_q  <= (state == SHIFT_DR) || (state == SHIFT_IR);
            case (state)
                SHIFT_IR: tdo_q <= ir_shift[0];
                SHIFT_DR: tdo_q <= sel_idcode_q ? bus.idcode_tdo : bypass_q;
                default:  tdo_q <= 1'b0;
            endcase
        end
    end

    // Enable only changes while tck is low, so the gated clock cannot glitch.
    assign bus.clockDR       = tck & dr_clk_en;
    assign bus.captureDR     = (state == CAP_DR);
    assign bus.shiftDR       = (state == SHIFT_DR);
    assign bus.updateDR      = (state == UPD_DR);
    assign bus.tdo           = tdo_q;
    assign bus.tdo_en        = tdo_en_q;
    assign bus.select_idcode = sel_idcode_q;
    assign bus.select_bypass = sel_bypass_q;
    assign bus.usercode_sel  = usercode_q;

endmodule
